// File: rtl/xillybus_bridge_pkg.sv
// Shared types and constants for the Xillybus <-> HLS ap_fifo stream bridge.
package xillybus_bridge_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_DEPTH_LOG2 = 9;
  localparam int unsigned CNT_W          = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sess_state_e;

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO with registered (non-FWFT) read data, registered flags and synchronous flush.
module bridge_sync_fifo
  import xillybus_bridge_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt_c;
  logic                  wr_ok_c;
  logic                  rd_ok_c;

  always_comb begin
    wr_ok_c     = wr_en && !full;
    rd_ok_c     = rd_en && !empty;
    count_nxt_c = count;
    case ({wr_ok_c, rd_ok_c})
      2'b10:   count_nxt_c = count + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_nxt_c = count - (DEPTH_LOG2 + 1)'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge bus_clk) begin
    if (wr_ok_c && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_ok_c) begin
        rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == FULL_CNT);
      empty <= (count_nxt_c == '0);
    end
  end

endmodule

// File: rtl/xillybus_hls_stream_bridge.sv
// Xillybus write/read device pair to HLS ap_fifo bridge: FIFOs, input prefetch,
// session FSM driving the HLS reset, drain-then-EOF and per-session word counters.
module xillybus_hls_stream_bridge
  import xillybus_bridge_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int unsigned EOF_MODE    = 1,
  parameter int unsigned DRAIN_QUIET = 16
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              user_w_open,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  output logic              user_w_full,
  input  logic              user_r_open,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  output logic              hls_rst,
  output logic [DATA_W-1:0] in_r_dout,
  output logic              in_r_empty_n,
  input  logic              in_r_read,
  input  logic [DATA_W-1:0] out_r_din,
  input  logic              out_r_write,
  output logic              out_r_full_n,
  output logic [CNT_W-1:0]  words_in,
  output logic [CNT_W-1:0]  words_out
);

  localparam int unsigned QW = $clog2(DRAIN_QUIET + 1);

  sess_state_e   state;
  sess_state_e   next_state;
  logic [QW-1:0] quiet_cnt;
  logic          w_open_q;
  logic          in_empty;
  logic          out_full;
  logic          flush_c;
  logic          hls_rst_nxt_c;
  logic          session_start_c;
  logic          in_wr_c;
  logic          out_wr_c;
  logic          out_rd_c;
  logic          fifo_rd_c;
  logic          quiet_busy_c;

  bridge_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_in_fifo (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .flush     (flush_c),
    .wr_en     (in_wr_c),
    .wr_data   (user_w_data),
    .rd_en     (fifo_rd_c),
    .rd_data   (in_r_dout),
    .full      (user_w_full),
    .empty     (in_empty)
  );

  bridge_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_out_fifo (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .flush     (flush_c),
    .wr_en     (out_wr_c),
    .wr_data   (out_r_din),
    .rd_en     (out_rd_c),
    .rd_data   (user_r_data),
    .full      (out_full),
    .empty     (user_r_empty)
  );

  assign out_r_full_n = !out_full;
  assign user_r_eof   = (state == DONE) && user_r_empty;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (user_w_open && user_r_open) next_state = RUN;
      RUN: begin
        if (!user_r_open)     next_state = IDLE;
        else if (!user_w_open) next_state = (EOF_MODE != 0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!user_r_open)                    next_state = IDLE;
        else if (quiet_cnt == QW'(DRAIN_QUIET)) next_state = DONE;
      end
      // A write-side reopen alone is ignored; a later close of either side ends the session.
      DONE:  if (!user_r_open || (w_open_q && !user_w_open)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Flushing keys off the next state so an abort empties everything on the same edge.
  always_comb begin
    flush_c         = (next_state == IDLE);
    hls_rst_nxt_c   = (next_state == IDLE) || (next_state == DONE);
    session_start_c = (state == IDLE) && (next_state == RUN);
    in_wr_c         = user_w_wren && !user_w_full && (state != IDLE) && !flush_c;
    out_wr_c        = out_r_write && !out_full && !flush_c;
    out_rd_c        = user_r_rden && !user_r_empty && !flush_c;
    fifo_rd_c       = !in_empty && (in_r_read || !in_r_empty_n);
    quiet_busy_c    = out_r_write || in_r_empty_n || !in_empty;
  end

  // ap_fifo prefetch stage in front of the HLS input port.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)     in_r_empty_n <= 1'b0;
    else if (flush_c)   in_r_empty_n <= 1'b0;
    else if (fifo_rd_c) in_r_empty_n <= 1'b1;
    else if (in_r_read) in_r_empty_n <= 1'b0;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      hls_rst   <= 1'b1;
      w_open_q  <= 1'b0;
      quiet_cnt <= '0;
      words_in  <= '0;
      words_out <= '0;
    end else begin
      hls_rst  <= hls_rst_nxt_c;
      w_open_q <= user_w_open;
      if ((state == DRAIN) && !quiet_busy_c) quiet_cnt <= quiet_cnt + QW'(1);
      else                                    quiet_cnt <= '0;
      if (session_start_c) begin
        words_in  <= '0;
        words_out <= '0;
      end else begin
        if (in_wr_c)  words_in  <= words_in + CNT_W'(1);
        if (out_rd_c) words_out <= words_out + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xillybus_hls_stream_bridge.sv
// Directed bench for the stream bridge: an EOF_MODE=1 instance with an HLS copy model,
// plus an EOF_MODE=0 instance for the legacy abort path.
module tb_xillybus_hls_stream_bridge;

  localparam int unsigned W = 32;

  logic         bus_clk = 1'b0;
  logic         bus_rst_n = 1'b0;
  logic         user_w_open = 1'b0, user_w_wren = 1'b0, user_r_open = 1'b0, user_r_rden = 1'b0;
  logic [W-1:0] user_w_data = '0;
  logic         user_w_full, user_r_empty, user_r_eof, hls_rst, in_r_empty_n, out_r_full_n;
  logic [W-1:0] user_r_data, in_r_dout, words_in, words_out;
  logic         in_r_read, out_r_write;
  logic [W-1:0] out_r_din;

  logic         hls_en = 1'b0, man_read = 1'b0, man_write = 1'b0;
  logic [W-1:0] man_din = '0;
  logic         model_go = 1'b0;
  logic [W-1:0] model_din = '0;

  logic         leg_w_open = 1'b0, leg_w_wren = 1'b0, leg_r_open = 1'b0;
  logic [W-1:0] leg_w_data = '0;
  logic         leg_w_full, leg_r_empty, leg_r_eof, leg_hls_rst, leg_in_empty_n, leg_out_full_n;
  logic [W-1:0] leg_r_data, leg_in_dout, leg_words_in, leg_words_out;

  int n_checks = 0;
  int n_fail = 0;

  always #5 bus_clk = ~bus_clk;

  // HLS core model: copies one word per cycle from input to output when both sides allow.
  always @(negedge bus_clk) begin
    model_go  <= hls_en && in_r_empty_n && out_r_full_n && !hls_rst;
    model_din <= in_r_dout;
  end
  assign in_r_read   = hls_en ? model_go  : man_read;
  assign out_r_write = hls_en ? model_go  : man_write;
  assign out_r_din   = hls_en ? model_din : man_din;

  xillybus_hls_stream_bridge #(.EOF_MODE(1)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_w_open(user_w_open), .user_w_wren(user_w_wren), .user_w_data(user_w_data),
    .user_w_full(user_w_full), .user_r_open(user_r_open), .user_r_rden(user_r_rden),
    .user_r_data(user_r_data), .user_r_empty(user_r_empty), .user_r_eof(user_r_eof),
    .hls_rst(hls_rst), .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n), .in_r_read(in_r_read),
    .out_r_din(out_r_din), .out_r_write(out_r_write), .out_r_full_n(out_r_full_n),
    .words_in(words_in), .words_out(words_out)
  );

  xillybus_hls_stream_bridge #(.EOF_MODE(0)) dut_leg (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_w_open(leg_w_open), .user_w_wren(leg_w_wren), .user_w_data(leg_w_data),
    .user_w_full(leg_w_full), .user_r_open(leg_r_open), .user_r_rden(1'b0),
    .user_r_data(leg_r_data), .user_r_empty(leg_r_empty), .user_r_eof(leg_r_eof),
    .hls_rst(leg_hls_rst), .in_r_dout(leg_in_dout), .in_r_empty_n(leg_in_empty_n), .in_r_read(1'b0),
    .out_r_din('0), .out_r_write(1'b0), .out_r_full_n(leg_out_full_n),
    .words_in(leg_words_in), .words_out(leg_words_out)
  );

  task automatic open_session();
    @(negedge bus_clk); user_w_open = 1'b1; user_r_open = 1'b1;
    @(negedge bus_clk);
  endtask

  task automatic close_session();
    @(negedge bus_clk); user_w_open = 1'b0; user_r_open = 1'b0; hls_en = 1'b0;
    @(negedge bus_clk);
  endtask

  task automatic test_reset();
    bus_rst_n = 1'b0;
    repeat (3) @(negedge bus_clk);
    n_checks++; if ({user_w_full, user_r_empty, user_r_eof, hls_rst, in_r_empty_n, out_r_full_n} !== 6'b010101) begin n_fail++; $display("FAIL reset_flags: got %b want 010101", {user_w_full, user_r_empty, user_r_eof, hls_rst, in_r_empty_n, out_r_full_n}); end
    n_checks++; if ((user_r_data | in_r_dout | words_in | words_out) !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", user_r_data, in_r_dout, words_in, words_out); end
    n_checks++; if ({leg_w_full, leg_r_empty, leg_r_eof, leg_hls_rst, leg_in_empty_n, leg_out_full_n} !== 6'b010101) begin n_fail++; $display("FAIL reset_leg_flags: got %b want 010101", {leg_w_full, leg_r_empty, leg_r_eof, leg_hls_rst, leg_in_empty_n, leg_out_full_n}); end
    n_checks++; if ((leg_r_data | leg_in_dout | leg_words_in | leg_words_out) !== '0) begin n_fail++; $display("FAIL reset_leg_data: got %h %h %h %h want 0", leg_r_data, leg_in_dout, leg_words_in, leg_words_out); end
    bus_rst_n = 1'b1;
    @(negedge bus_clk);
    n_checks++; if (hls_rst !== 1'b1) begin n_fail++; $display("FAIL idle_hls_rst: got %b want 1", hls_rst); end
  endtask

  task automatic test_prefetch();
    open_session();
    n_checks++; if (hls_rst !== 1'b0) begin n_fail++; $display("FAIL run_hls_rst: got %b want 0", hls_rst); end
    user_w_wren = 1'b1; user_w_data = 32'hDEADBEEF;
    @(negedge bus_clk); user_w_wren = 1'b0;
    n_checks++; if (in_r_empty_n !== 1'b0) begin n_fail++; $display("FAIL prefetch_early: got %b want 0", in_r_empty_n); end
    @(negedge bus_clk);
    n_checks++; if (in_r_empty_n !== 1'b1) begin n_fail++; $display("FAIL prefetch_valid: got %b want 1", in_r_empty_n); end
    n_checks++; if (in_r_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL prefetch_dout: got %h want deadbeef", in_r_dout); end
    man_read = 1'b1;
    @(negedge bus_clk); man_read = 1'b0;
    n_checks++; if (in_r_empty_n !== 1'b0) begin n_fail++; $display("FAIL prefetch_consume: got %b want 0", in_r_empty_n); end
    n_checks++; if (words_in !== 32'd1) begin n_fail++; $display("FAIL prefetch_words_in: got %0d want 1", words_in); end
    close_session();
  endtask

  task automatic test_back_pressure();
    open_session();
    for (int i = 0; i < 512; i++) begin
      @(negedge bus_clk);
      if (i == 511) begin
        n_checks++; if (out_r_full_n !== 1'b1) begin n_fail++; $display("FAIL bp_511_full_n: got %b want 1", out_r_full_n); end
      end
      man_write = 1'b1; man_din = 32'hB000_0000 + W'(i);
    end
    @(negedge bus_clk);
    n_checks++; if (out_r_full_n !== 1'b0) begin n_fail++; $display("FAIL bp_full_n: got %b want 0", out_r_full_n); end
    man_din = 32'h0000_0BAD;
    @(negedge bus_clk); man_write = 1'b0;
    n_checks++; if (out_r_full_n !== 1'b0) begin n_fail++; $display("FAIL bp_extra_write: got %b want 0", out_r_full_n); end
    user_r_rden = 1'b1;
    @(negedge bus_clk); user_r_rden = 1'b0;
    n_checks++; if (out_r_full_n !== 1'b1) begin n_fail++; $display("FAIL bp_after_rden: got %b want 1", out_r_full_n); end
    n_checks++; if (user_r_data !== 32'hB000_0000) begin n_fail++; $display("FAIL bp_first_word: got %h want b0000000", user_r_data); end
    for (int i = 1; i < 512; i++) begin
      user_r_rden = 1'b1;
      @(negedge bus_clk);
      n_checks++; if (user_r_data !== 32'hB000_0000 + W'(i)) begin n_fail++; $display("FAIL bp_word_%0d: got %h want %h", i, user_r_data, 32'hB000_0000 + W'(i)); end
    end
    user_r_rden = 1'b0;
    n_checks++; if (user_r_empty !== 1'b1) begin n_fail++; $display("FAIL bp_empty_after: got %b want 1", user_r_empty); end
    n_checks++; if (words_out !== 32'd512) begin n_fail++; $display("FAIL bp_words_out: got %0d want 512", words_out); end
    close_session();
  endtask

  task automatic test_loopback();
    int unsigned wr_next = 1;
    int unsigned rd_exp = 1;
    int cyc = 0;
    int full_seen = 0;
    bit rd_pend = 1'b0;
    open_session();
    while (rd_exp <= 1024 && cyc < 20000) begin
      @(negedge bus_clk); cyc++;
      if (rd_pend) begin
        n_checks++; if (user_r_data !== W'(rd_exp)) begin n_fail++; $display("FAIL loop_word: got %h want %h", user_r_data, W'(rd_exp)); end
        rd_exp++;
      end
      if (cyc == 700) hls_en = 1'b1;
      if (wr_next <= 1024) begin
        user_w_wren = 1'b1; user_w_data = W'(wr_next);
        if (user_w_full) full_seen++;
        else             wr_next++;
      end else user_w_wren = 1'b0;
      user_r_rden = (cyc >= 700);
      rd_pend = user_r_rden && !user_r_empty;
    end
    user_w_wren = 1'b0; user_r_rden = 1'b0;
    @(negedge bus_clk);
    n_checks++; if (rd_exp !== 32'd1025) begin n_fail++; $display("FAIL loop_count: got %0d want 1024 words read", rd_exp - 1); end
    n_checks++; if (full_seen == 0) begin n_fail++; $display("FAIL loop_full_seen: got %0d stalled cycles want >0", full_seen); end
    n_checks++; if (words_in !== 32'd1024) begin n_fail++; $display("FAIL loop_words_in: got %0d want 1024", words_in); end
    n_checks++; if (words_out !== 32'd1024) begin n_fail++; $display("FAIL loop_words_out: got %0d want 1024", words_out); end
    close_session();
  endtask

  task automatic test_drain_eof();
    int cyc = 0;
    open_session();
    hls_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      user_w_wren = 1'b1; user_w_data = 32'h1000 + W'(i);
      @(negedge bus_clk);
    end
    user_w_wren = 1'b0; user_w_open = 1'b0;
    @(negedge bus_clk);
    n_checks++; if (hls_rst !== 1'b0) begin n_fail++; $display("FAIL drain_hls_rst: got %b want 0", hls_rst); end
    while (!hls_rst && cyc < 500) begin @(negedge bus_clk); cyc++; end
    n_checks++; if (hls_rst !== 1'b1) begin n_fail++; $display("FAIL done_hls_rst: got %b want 1 within 500 cycles", hls_rst); end
    n_checks++; if ({user_r_empty, user_r_eof} !== 2'b00) begin n_fail++; $display("FAIL done_pending: got empty,eof=%b want 00", {user_r_empty, user_r_eof}); end
    n_checks++; if (words_in !== 32'd100) begin n_fail++; $display("FAIL drain_words_in: got %0d want 100", words_in); end
    for (int i = 0; i < 100; i++) begin
      user_r_rden = 1'b1;
      @(negedge bus_clk);
      n_checks++; if (user_r_data !== 32'h1000 + W'(i)) begin n_fail++; $display("FAIL drain_word_%0d: got %h want %h", i, user_r_data, 32'h1000 + W'(i)); end
      n_checks++; if (user_r_eof !== (i == 99)) begin n_fail++; $display("FAIL drain_eof_%0d: got %b want %b", i, user_r_eof, (i == 99)); end
    end
    user_r_rden = 1'b0;
    n_checks++; if (user_r_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", user_r_empty); end
    n_checks++; if (words_out !== 32'd100) begin n_fail++; $display("FAIL drain_words_out: got %0d want 100", words_out); end
    close_session();
    n_checks++; if ({hls_rst, user_r_eof} !== 2'b10) begin n_fail++; $display("FAIL idle_after_done: got hls_rst,eof=%b want 10", {hls_rst, user_r_eof}); end
    n_checks++; if (words_out !== 32'd100) begin n_fail++; $display("FAIL idle_words_hold: got %0d want 100", words_out); end
  endtask

  task automatic test_legacy_abort();
    @(negedge bus_clk); leg_w_open = 1'b1; leg_r_open = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge bus_clk); leg_w_wren = 1'b1; leg_w_data = 32'h3000 + W'(i);
    end
    @(negedge bus_clk); leg_w_wren = 1'b0;
    n_checks++; if ({leg_in_empty_n, leg_hls_rst} !== 2'b10) begin n_fail++; $display("FAIL leg_running: got empty_n,hls_rst=%b want 10", {leg_in_empty_n, leg_hls_rst}); end
    n_checks++; if (leg_words_in !== 32'd50) begin n_fail++; $display("FAIL leg_words_in: got %0d want 50", leg_words_in); end
    leg_w_open = 1'b0;
    @(negedge bus_clk);
    n_checks++; if ({leg_hls_rst, leg_in_empty_n, leg_r_empty, leg_r_eof, leg_w_full} !== 5'b10100) begin n_fail++; $display("FAIL leg_abort: got %b want 10100", {leg_hls_rst, leg_in_empty_n, leg_r_empty, leg_r_eof, leg_w_full}); end
    leg_w_open = 1'b1;
    repeat (3) @(negedge bus_clk);
    n_checks++; if ({leg_hls_rst, leg_in_empty_n} !== 2'b00) begin n_fail++; $display("FAIL leg_reopen_flushed: got hls_rst,empty_n=%b want 00", {leg_hls_rst, leg_in_empty_n}); end
    n_checks++; if (leg_words_in !== 32'd0) begin n_fail++; $display("FAIL leg_reopen_words: got %0d want 0", leg_words_in); end
    leg_w_open = 1'b0; leg_r_open = 1'b0;
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    open_session();
    hls_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      user_w_wren = 1'b1; user_w_data = 32'h2000 + W'(i);
      @(negedge bus_clk);
    end
    user_w_wren = 1'b0;
    repeat (5) @(negedge bus_clk);
    hls_en = 1'b0;
    for (int i = 10; i < 15; i++) begin
      user_w_wren = 1'b1; user_w_data = 32'h2000 + W'(i);
      @(negedge bus_clk);
    end
    user_w_wren = 1'b0; user_r_rden = 1'b1;
    @(negedge bus_clk); user_r_rden = 1'b0;
    n_checks++; if ({user_r_empty, in_r_empty_n, user_r_data} !== {2'b01, 32'h2000}) begin n_fail++; $display("FAIL arst_pre: got empty=%b empty_n=%b data=%h want 0 1 2000", user_r_empty, in_r_empty_n, user_r_data); end
    #2 bus_rst_n = 1'b0;
    #1;
    n_checks++; if ({user_w_full, user_r_empty, user_r_eof, hls_rst, in_r_empty_n, out_r_full_n} !== 6'b010101) begin n_fail++; $display("FAIL arst_flags: got %b want 010101", {user_w_full, user_r_empty, user_r_eof, hls_rst, in_r_empty_n, out_r_full_n}); end
    n_checks++; if ((user_r_data | in_r_dout | words_in | words_out) !== '0) begin n_fail++; $display("FAIL arst_data: got %h %h %h %h want 0", user_r_data, in_r_dout, words_in, words_out); end
    @(negedge bus_clk); bus_rst_n = 1'b1; hls_en = 1'b1;
    @(negedge bus_clk);
    user_w_wren = 1'b1; user_w_data = 32'h5555_0001;
    @(negedge bus_clk); user_w_wren = 1'b0;
    while (user_r_empty && cyc < 50) begin @(negedge bus_clk); cyc++; end
    user_r_rden = 1'b1;
    @(negedge bus_clk); user_r_rden = 1'b0;
    n_checks++; if (user_r_data !== 32'h5555_0001) begin n_fail++; $display("FAIL arst_first_word: got %h want 55550001", user_r_data); end
    n_checks++; if ({words_in, words_out} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL arst_words: got %0d %0d want 1 1", words_in, words_out); end
    close_session();
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_back_pressure();
    test_loopback();
    test_drain_eof();
    test_legacy_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
